// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // STATUS word bit positions; count occupies three bits from ST_COUNT_LSB.
  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  function automatic logic [2:0] sat_count(input logic [31:0] c);
    return (c > 32'd7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the UART shifter; head is visible on dout while non-empty.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store-driven TX FIFO, pollable STATUS,
// and a shifter FSM that sends frames back-to-back while data is queued.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FFE0,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        read_hit,
  output logic        tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift_q;
  logic           tx_q;
  logic           overflow;

  logic           fifo_push;
  logic           fifo_pop;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  logic           wr_hit;
  logic           push_req;
  logic           ovf_clr;
  logic           rd_in_win;
  logic           baud_tick;
  logic [BW-1:0]  baud_next;
  logic [31:0]    status_word;
  logic           unused_bits;

  // Width and byte-offset bits are deliberately ignored: every access is a word.
  assign unused_bits = ^{funct3, write_address[1:0], read_address[1:0], write_data[31:8]};

  assign wr_hit    = write_mem && (write_address[31:4] == BASE_ADDR[31:4]);
  assign push_req  = wr_hit && (write_address[3:2] == REG_TXDATA);
  assign ovf_clr   = wr_hit && (write_address[3:2] == REG_STATUS) && write_data[3];
  assign rd_in_win = (read_address[31:4] == BASE_ADDR[31:4]);
  assign fifo_push = push_req;

  assign baud_tick = (baud_cnt == BAUD_LAST);
  assign baud_next = baud_tick ? '0 : baud_cnt + 1'b1;

  // The shifter takes the FIFO head when idle, or at the end of a stop bit.
  assign fifo_pop = !fifo_empty &&
                    ((state == IDLE) || ((state == STOP) && baud_tick));

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (write_data[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word                          = '0;
    status_word[ST_BUSY]                 = (state != IDLE);
    status_word[ST_FULL]                 = fifo_full;
    status_word[ST_EMPTY]                = fifo_empty;
    status_word[ST_OVERFLOW]             = overflow;
    status_word[ST_COUNT_LSB +: 3]       = sat_count(32'(fifo_count));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= '0;
      read_hit  <= 1'b0;
    end else begin
      read_hit  <= rd_in_win;
      read_data <= (rd_in_win && (read_address[3:2] == REG_STATUS)) ? status_word : '0;
    end
  end

  // tx_q holds the level for the coming bit period, so tx is a pure flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q  <= fifo_dout;
            baud_cnt <= '0;
            state    <= START;
            tx_q     <= 1'b0;
          end
        end
        START: begin
          baud_cnt <= baud_next;
          if (baud_tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          baud_cnt <= baud_next;
          if (baud_tick) begin
            shift_q <= shift_q >> 1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift_q[1];
            end
          end
        end
        STOP: begin
          baud_cnt <= baud_next;
          if (baud_tick) begin
            if (!fifo_empty) begin
              shift_q <= fifo_dout;
              state   <= START;
              tx_q    <= 1'b0;
            end else begin
              state <= IDLE;
              tx_q  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-timeline reference model, line monitor,
// directed scenarios and a randomized bus phase.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'hFFFF_FFE0;

  logic        clk;
  logic        rst_n;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        read_hit;
  logic        tx;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .write_mem     (write_mem),
    .funct3        (funct3),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address),
    .read_data     (read_data),
    .read_hit      (read_hit),
    .tx            (tx)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // A frame is a fixed 10*CPB-cycle window starting at the pop edge; pops
  // happen when no frame is running (or one ends this edge) and data is queued.
  logic [7:0]  exp_q[$];
  int          rem = 0;
  logic [7:0]  cur = '0;
  bit          ovf = 0;
  logic [31:0] exp_rd = '0;
  logic        exp_hit = 1'b0;
  int          mdl_frames = 0;

  function automatic int sat7(input int c);
    return (c > 7) ? 7 : c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      rem     = 0;
      ovf     = 0;
      exp_rd  = '0;
      exp_hit = 1'b0;
      cur     = '0;
    end else begin
      int occ;
      bit wr_in;
      occ     = exp_q.size();
      exp_hit = (read_address[31:4] == BASE[31:4]);
      exp_rd  = '0;
      if (exp_hit && read_address[3:2] == 2'd1)
        exp_rd = 32'(sat7(occ) * 16 + (ovf ? 8 : 0) + (occ == 0 ? 4 : 0)
                      + (occ == DEPTH ? 2 : 0) + (rem > 0 ? 1 : 0));
      wr_in = write_mem && (write_address[31:4] == BASE[31:4]);
      if (wr_in && write_address[3:2] == 2'd1 && write_data[3]) ovf = 0;
      if (rem > 0) rem--;
      if (rem == 0 && occ > 0) begin
        cur = exp_q.pop_front();
        rem = FRAME;
        mdl_frames++;
      end
      if (wr_in && write_address[3:2] == 2'd0) begin
        if (occ < DEPTH) exp_q.push_back(write_data[7:0]);
        else ovf = 1;
      end
    end
  end

  // Every cycle: line level, load hit and load data against the model.
  always @(negedge clk) begin
    logic exp_tx;
    int   p;
    int   b;
    if (rem == 0) begin
      exp_tx = 1'b1;
    end else begin
      p = FRAME - rem;
      b = p / CPB;
      if (b == 0)      exp_tx = 1'b0;
      else if (b == 9) exp_tx = 1'b1;
      else             exp_tx = cur[b-1];
    end
    check_eq("tx", {31'b0, tx}, {31'b0, exp_tx});
    check_eq("rd_hit", {31'b0, read_hit}, {31'b0, exp_hit});
    check_eq("rd_data", read_data, exp_rd);
  end

  // ---------------- line monitor ----------------
  int mon_frames = 0;
  int mon_k      = 0;
  bit mon_in     = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_in = 0;
      mon_k  = 0;
    end else if (!mon_in) begin
      if (tx == 1'b0) begin
        mon_in = 1;
        mon_k  = 1;
      end
    end else begin
      mon_k++;
      if (mon_k == FRAME) begin
        mon_in = 0;
        mon_frames++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    write_mem     = 1'b1;
    write_address = a;
    write_data    = d;
    @(negedge clk);
    write_mem     = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    read_address = a;
    @(negedge clk);
    read_address = 32'h0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!(rem == 0 && exp_q.size() == 0 && !mon_in) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'b0, (n < max_cycles)}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int f0;
    bit a5_bits[10];
    a5_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    rst_n         = 1'b0;
    write_mem     = 1'b0;
    funct3        = 3'b010;
    write_address = '0;
    write_data    = '0;
    read_address  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check_eq("idle_tx_high_cycles_low", 32'(bad), 32'd0);
    load(BASE + 32'd4);
    check_eq("reset_status", read_data, 32'h0000_0004);
    check_eq("reset_status_hit", {31'b0, read_hit}, 32'd1);

    // Single frame 0xA5
    f0 = mon_frames;
    store(BASE, 32'h0000_00A5);
    check_eq("a5_tx_high_after_store", {31'b0, tx}, 32'd1);
    for (int b = 0; b < 10; b++) begin
      repeat ((b == 0) ? 1 : CPB) @(negedge clk);
      check_eq($sformatf("a5_bit%0d", b), {31'b0, tx}, {31'b0, a5_bits[b]});
    end
    wait_idle("a5_idle_timeout", 20);
    check_eq("a5_frames", 32'(mon_frames - f0), 32'd1);

    // Three back-to-back frames
    f0 = mon_frames;
    store(BASE, 32'h11);
    store(BASE, 32'h22);
    store(BASE, 32'h33);
    repeat (3 * FRAME - 2) @(negedge clk);
    check_eq("b2b_still_in_frame", {31'b0, mon_in}, 32'd1);
    wait_idle("b2b_idle_timeout", 20);
    check_eq("b2b_frames", 32'(mon_frames - f0), 32'd3);
    load(BASE + 32'd4);
    check_eq("b2b_status_idle", read_data, 32'h0000_0004);

    // Overflow: six stores, one dropped
    f0 = mon_frames;
    for (int i = 0; i < 6; i++) store(BASE, 32'(8'h40 + i));
    load(BASE + 32'd4);
    check_eq("ovf_status", read_data, 32'h0000_004B);
    store(BASE + 32'd4, 32'h8);
    load(BASE + 32'd4);
    check_eq("ovf_cleared_status", read_data, 32'h0000_0043);
    wait_idle("ovf_idle_timeout", 6 * FRAME);
    check_eq("ovf_frames", 32'(mon_frames - f0), 32'd5);

    // Window decode
    load(BASE + 32'd4);
    check_eq("win_hit", {31'b0, read_hit}, 32'd1);
    load(32'h0000_0100);
    check_eq("oow_hit", {31'b0, read_hit}, 32'd0);
    check_eq("oow_data", read_data, 32'h0);
    load(BASE + 32'd8);
    check_eq("reserved_read", read_data, 32'h0);
    f0 = mon_frames;
    store(32'h0000_0100, 32'h55);
    store(BASE + 32'd12, 32'h66);
    repeat (50) @(negedge clk);
    check_eq("oow_store_no_frame", 32'(mon_frames - f0), 32'd0);

    // Randomized bus traffic
    for (int it = 0; it < 400; it++) begin
      int op;
      op     = $urandom_range(0, 9);
      funct3 = 3'($urandom_range(0, 7));
      case (op)
        0, 1, 2, 3, 4: store(BASE + 32'($urandom_range(0, 3)), $urandom());
        5:             store(BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom());
        6:             store(BASE + 32'd8 + 32'($urandom_range(0, 7)), $urandom());
        7:             load(BASE + 32'($urandom_range(0, 15)));
        8: begin
          if ($urandom_range(0, 1) == 1) store($urandom(), $urandom());
          else load($urandom());
        end
        default:       repeat ($urandom_range(0, 60)) @(negedge clk);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("rand_idle_timeout", 2000);
    check_eq("rand_frame_total", 32'(mon_frames), 32'(mdl_frames));

    // Reset mid-DATA
    store(BASE, 32'h3C);
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_tx", {31'b0, tx}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = mon_frames;
    repeat (60) @(negedge clk);
    check_eq("post_reset_no_frame", 32'(mon_frames - f0), 32'd0);
    load(BASE + 32'd4);
    check_eq("post_reset_status", read_data, 32'h0000_0004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds to the processor's load/store bus, the same write/read signal set the data memory uses. Stores to its window push bytes into a small FIFO. An internal state machine serialises each byte as an 8N1 frame on `tx`. Loads return status so firmware can poll before writing. It sits beside `memory` in `top`; `read_hit` lets `top` select its `read_data` over memory's.

## Interface
Parameters:
- `BASE_ADDR`, 32'hFFFF_FFE0: word-aligned base of the 16-byte register window.
- `CLKS_PER_BIT`, 104: clock cycles per UART bit (12 MHz / 115200). Legal range is ≥2.
- `FIFO_DEPTH`, 4: TX FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `write_mem` in 1: store strobe, one cycle per store.
- `funct3` in 3: store/load size. Ignored; every access is treated as a word.
- `write_address` in 32: store address.
- `write_data` in 32: store data.
- `read_address` in 32: load address.
- `read_data` out 32: registered load data.
- `read_hit` out 1: registered; 1 when the previous cycle's `read_address` was inside the window.
- `tx` out 1: serial output, idle high.

## Operation
- Decode uses `addr[31:4] == BASE_ADDR[31:4]` and `addr[3:2]` as the register index. `addr[1:0]` is ignored.
- Register 0, TXDATA (BASE+0):
  - Store pushes `write_data[7:0]` if the FIFO is not full.
  - If the FIFO is full, the store is dropped and the sticky `overflow` bit is set.
  - Load returns 0.
- Register 1, STATUS (BASE+4). Load returns:
  - `{25'b0, count[2:0], overflow, empty, full, busy}`, where bit0 is `busy`.
  - `busy` = shifter not IDLE.
  - `count` = FIFO occupancy, saturating at 7 for display.
- Writing STATUS with `write_data[3]=1` clears `overflow`. Other bits are ignored.
- Registers 2 and 3 are reserved: loads return 0, stores have no effect.
- Out-of-window accesses: stores are ignored; loads give `read_data=0` and `read_hit=0`.
- Push rule: acceptance is judged on occupancy *before* the edge. A push to a full FIFO is dropped even if a pop happens in the same cycle. A simultaneous push and pop on a non-full FIFO leaves `count` unchanged.
- Shifter FSM: IDLE → START → DATA → STOP → (IDLE or START).
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, go to START.
  - START: `tx=0` for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx=shift[0]` for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. Go to STOP after bit index 7.
  - STOP: `tx=1` for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- The baud counter runs from 0 to CLKS_PER_BIT-1 and wraps. A bit boundary is the cycle where the counter equals CLKS_PER_BIT-1.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. `count` is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - `tx=1`, `read_data=0`, `read_hit=0`.
  - FIFO empty, `overflow=0`, FSM IDLE, all counters 0.
- A reset mid-frame aborts the frame immediately; `tx` goes high without waiting for a clock.
- Store to TXDATA at edge N with the FIFO empty and FSM IDLE:
  - The FIFO becomes non-empty after edge N.
  - The pop and START happen at edge N+1, so `tx` falls after edge N+1.
  - The frame lasts exactly 10·CLKS_PER_BIT cycles.
- Load: `read_address` is sampled at edge N; `read_data` and `read_hit` are valid after edge N, with 1-cycle latency, matching memory.
- STATUS reflects state as of the sampling edge. A push and a STATUS read at the same edge show the pre-push `count`.
- `tx` is driven directly from a flop. There is no combinational path from any input to `tx`.

## Structure
- Package `uart_pkg`:
  - register index constants `REG_TXDATA=2'd0`, `REG_STATUS=2'd1`;
  - status bit positions;
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t`.
- Sub-module `tx_fifo` (parameter `DEPTH`, width 8):
  - inputs `clk`, `rst_n`, `push`, `din`, `pop`;
  - outputs `dout`, `full`, `empty`, `count`.
- The top level holds address decode, the status/overflow logic and the shifter FSM.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset, then idle 50 cycles → `tx=1` throughout; STATUS load reads 32'h0000_0004 (empty only).
- Store 32'h0000_00A5 to BASE+0 → `tx` falls 1 cycle after the store edge. Bits then sampled every 4 cycles read 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop). Total 40 cycles.
- Store 0x11, 0x22, 0x33 on consecutive cycles → three frames back-to-back with no idle gap (120 cycles); then `busy=0`, `empty=1`.
- Store 6 bytes on consecutive cycles → first byte popped and 4 held, so the 6th is dropped. STATUS reads `overflow=1`, `full=1`. Writing 32'h8 to BASE+4 clears `overflow`. Exactly 5 frames are sent.
- Load BASE+4 and load address 32'h0000_0100 → `read_hit` is 1 then 0, one cycle after each load; the out-of-window `read_data` is 0. Store to 32'h0000_0100 → no frame.
- Assert `rst_n=0` mid-DATA for 3 cycles → `tx=1` asynchronously. After release, FIFO is empty and no further frames are sent.
